// File: rtl/audio_mem_arbiter.sv
// Round-robin arbiter sequencing the async audio sample SRAM between record (write) and playback (read).
// Optional AUDIO_MEM_ARB_PLAY_PRIO_EN gives playback fixed priority on ties.
module audio_mem_arbiter #(
   parameter int ADDR_W      = 24,
   parameter int DATA_W      = 16,
   parameter int WAIT_CYCLES = 7
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rec_req,
   input  logic [ADDR_W-1:0] rec_addr,
   input  logic [DATA_W-1:0] rec_wdata,
   output logic              rec_ack,
   input  logic              play_req,
   input  logic [ADDR_W-1:0] play_addr,
   output logic [DATA_W-1:0] play_rdata,
   output logic              play_ack,
   output logic [ADDR_W+1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_data_oe,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              mem_ce_n,
   output logic              mem_oe_n,
   output logic              mem_we_n,
   output logic              mem_ub_n,
   output logic              mem_lb_n,
   output logic              busy
);

   // state  | meaning
   // IDLE   | sample requests, grant and latch one
   // SETUP  | chip enabled, address/data driven, strobes high
   // ACCESS | we_n or oe_n low for WAIT_CYCLES cycles
   // HOLD   | strobes high, ack to the granted requester
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

   state_t      state, state_d;
   logic [7:0]  wait_cnt, wait_cnt_d;
   logic        last_grant;   // 1: playback won last
   logic        dir_write, dir_write_d;
   logic        grant_en, grant_play;
   logic        ce_n_d, oe_n_d, we_n_d, data_oe_d, rec_ack_d, play_ack_d, busy_d;

   assign grant_en = (state == IDLE) && (rec_req || play_req);

`ifdef AUDIO_MEM_ARB_PLAY_PRIO_EN
   assign grant_play = play_req;
`else
   assign grant_play = play_req && (!rec_req || !last_grant);
`endif

   always_comb begin
      state_d     = state;
      wait_cnt_d  = wait_cnt;
      dir_write_d = dir_write;
      case (state)
         IDLE: begin
            if (grant_en) begin
               state_d     = SETUP;
               dir_write_d = !grant_play;
            end
         end
         SETUP: begin
            state_d    = ACCESS;
            wait_cnt_d = 8'(WAIT_CYCLES - 1);
         end
         ACCESS: begin
            if (wait_cnt == 8'd0) state_d = HOLD;
            else                  wait_cnt_d = wait_cnt - 8'd1;
         end
         HOLD:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so every pin comes straight from a flop.
   always_comb begin
      ce_n_d     = (state_d == IDLE);
      oe_n_d     = !((state_d == ACCESS) && !dir_write_d);
      we_n_d     = !((state_d == ACCESS) && dir_write_d);
      data_oe_d  = (state_d != IDLE) && dir_write_d;
      rec_ack_d  = (state_d == HOLD) && dir_write_d;
      play_ack_d = (state_d == HOLD) && !dir_write_d;
      busy_d     = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         wait_cnt    <= '0;
         last_grant  <= 1'b0;
         dir_write   <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         play_rdata  <= '0;
         mem_ce_n    <= 1'b1;
         mem_oe_n    <= 1'b1;
         mem_we_n    <= 1'b1;
         mem_ub_n    <= 1'b1;
         mem_lb_n    <= 1'b1;
         mem_data_oe <= 1'b0;
         rec_ack     <= 1'b0;
         play_ack    <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state       <= state_d;
         wait_cnt    <= wait_cnt_d;
         dir_write   <= dir_write_d;
         mem_ce_n    <= ce_n_d;
         mem_oe_n    <= oe_n_d;
         mem_we_n    <= we_n_d;
         mem_ub_n    <= ce_n_d;
         mem_lb_n    <= ce_n_d;
         mem_data_oe <= data_oe_d;
         rec_ack     <= rec_ack_d;
         play_ack    <= play_ack_d;
         busy        <= busy_d;
         if (grant_en) begin
            last_grant <= grant_play;
            mem_addr   <= {2'b00, (grant_play ? play_addr : rec_addr)};
            if (!grant_play) mem_wdata <= rec_wdata;
         end
         if ((state == ACCESS) && (wait_cnt == 8'd0) && !dir_write)
            play_rdata <= mem_rdata;
      end
   end

endmodule

// File: doc/audio_mem_arbiter.md
# audio_mem_arbiter

Sequences the asynchronous external audio sample memory and shares it between two requesters: the record path, which writes, and the playback path, which reads. Each granted request runs one complete SRAM-style access with programmable wait states, then returns a one-cycle acknowledge. Request addresses are 24-bit word addresses and are driven to the 26-bit memory address bus zero-extended as {2'b00, addr}.

## Interface
- ADDR_W, 24, requester word-address width
- DATA_W, 16, sample/data width
- WAIT_CYCLES, 7, cycles the strobe (we_n/oe_n) is held low; legal range 1..255
- clk  input  1  system clock; all logic is on the rising edge
- rst  input  1  synchronous, active-high reset
- rec_req  input  1  record write request; held high until rec_ack
- rec_addr  input  24  write word address; stable while rec_req is high
- rec_wdata  input  16  write data; stable while rec_req is high
- rec_ack  output  1  one-cycle pulse: write complete
- play_req  input  1  playback read request; held high until play_ack
- play_addr  input  24  read word address; stable while play_req is high
- play_rdata  output  16  read data; valid from the play_ack cycle until the next read completes
- play_ack  output  1  one-cycle pulse: read complete
- mem_addr  output  26  {2'b00, latched address}
- mem_wdata  output  16  write data to the pad tristate
- mem_data_oe  output  1  pad output enable; high for writes, from SETUP through HOLD
- mem_rdata  input  16  data from the pad
- mem_ce_n, mem_oe_n, mem_we_n, mem_ub_n, mem_lb_n  output  1 each  memory controls, active low
- busy  output  1  high whenever state is not IDLE

## Operation
- States: IDLE, SETUP, ACCESS, HOLD.
- **IDLE**
  - Samples both requests.
  - If either is high, grant one, latch its address, write data and direction, then go to SETUP.
  - Otherwise stay in IDLE.
- **SETUP** (1 cycle)
  - ce_n=0, ub_n=lb_n=0; address and data are driven.
  - we_n=1, oe_n=1.
  - Go to ACCESS with the wait counter loaded to WAIT_CYCLES-1.
- **ACCESS** (WAIT_CYCLES cycles)
  - Write: we_n=0. Read: oe_n=0.
  - The counter decrements each cycle.
  - For reads, mem_rdata is registered into play_rdata on the clock edge that ends the last ACCESS cycle.
  - Go to HOLD when the counter reaches 0.
- **HOLD** (1 cycle)
  - we_n=oe_n=1; ce_n, address and data are still held.
  - The granted requester's ack is high for this cycle only.
  - Return to IDLE.
- **Arbitration** is round-robin.
  - A last_grant register records the most recent winner.
  - When both requests are high in IDLE, the requester that was not last granted wins.
  - A lone requester is always granted.
  - last_grant resets to record, so the first tie goes to playback.
- **Request protocol**
  - A requester drops req in the cycle after ack.
  - Because req is sampled only in IDLE, a dropped req is never re-granted.
  - A req still high in IDLE after its ack starts a new transaction.
- Changes to address, data or req while busy are ignored; only the latched values are used.

## Timing
- **Reset values**
  - mem_ce_n, mem_oe_n, mem_we_n, mem_ub_n, mem_lb_n = 1.
  - mem_addr=0, mem_wdata=0, mem_data_oe=0.
  - rec_ack=play_ack=0, play_rdata=0, busy=0.
  - State is IDLE; last_grant is record.
- All outputs are registered; there are no combinational paths from input to output.
- **Latency:** req first high in IDLE cycle T gives SETUP at T+1, ACCESS at T+2..T+WAIT_CYCLES+1, and ack at T+WAIT_CYCLES+2. With the default, ack is at T+9.
- **Throughput:** minimum transaction period is WAIT_CYCLES+3 cycles, because of the mandatory IDLE cycle between accesses. With the default this is 10 cycles.
- **Reset mid-transaction:** on the next edge all controls go inactive, no ack is issued, the state returns to IDLE, and the aborted request is not retried automatically.
- If both requests rise in the same IDLE cycle, exactly one is granted. The other is served in the next transaction provided it is still high.

## Configuration
- AUDIO_MEM_ARB_PLAY_PRIO_EN
- **Defined:** playback has fixed priority. play_req wins every tie in IDLE, last_grant is not consulted, and the record path may starve under continuous playback.
- **Undefined:** round-robin as described under Operation.

## Test plan
- **Single write:** reset, then rec_req=1, rec_addr=24'h00_1234, rec_wdata=16'hBEEF.
  - mem_addr=26'h000_1234 and mem_data_oe=1 from SETUP through HOLD.
  - we_n low for exactly 7 cycles.
  - rec_ack one cycle at T+9; busy is low again at T+10.
- **Single read:** play_req=1, play_addr=24'hFF_FFFF, mem_rdata model returns 16'hA5C3 while oe_n=0.
  - mem_addr=26'h0FF_FFFF.
  - play_rdata=16'hA5C3 with play_ack at T+9.
  - mem_data_oe stays 0 throughout.
- **Tie after reset:** both requests rise together.
  - Playback is served first (ack at T+9).
  - Record is served next, ack at T+19.
  - Repeat the tie: grants alternate.
- **Reset mid-access:** assert rst during the 3rd ACCESS cycle of a write.
  - Next cycle: we_n=ce_n=1, data_oe=0, busy=0.
  - No rec_ack is issued.
- **WAIT_CYCLES=1:** sequence is IDLE, SETUP, one ACCESS cycle, HOLD, with ack at T+3.
  - Under continuous requests, back-to-back period is 4 cycles.
- **AUDIO_MEM_ARB_PLAY_PRIO_EN defined:** hold both requests high for 5 transactions.
  - All 5 grants go to playback.
  - rec_ack never asserts.
